// File: rtl/one_hot_pkg.sv
// rtl/one_hot_pkg.sv - one-hot helpers shared by the one-hot mux, its arbiters and the demux
package one_hot_pkg;

    localparam int MAX_N = 32;
    localparam int IDX_W = $clog2(MAX_N);

    // Callers zero-extend narrower selects to MAX_N bits.
    function automatic bit is_onehot(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/one_hot_demux_if.sv
// rtl/one_hot_demux_if.sv - producer-side and per-lane consumer-side handshake bundle
interface one_hot_demux_if #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 8
);
    logic                      in_valid_i;
    logic [NUM_OUT-1:0]        in_sel_i;
    logic [DATA_W-1:0]         in_data_i;
    logic                      in_ready_o;
    logic [NUM_OUT-1:0]        out_valid_o;
    logic [NUM_OUT*DATA_W-1:0] out_data_o;
    logic [NUM_OUT-1:0]        out_ready_i;

    modport master (
        output in_valid_i, in_sel_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );

    modport slave (
        input  in_valid_i, in_sel_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/one_hot_demux_slot.sv
// rtl/one_hot_demux_slot.sv - demux_slot: 1-entry valid/ready register slice for one output lane
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              free_o
);
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d, data_q;

    // A load while draining keeps valid high, giving one beat per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) valid_d = 1'b0;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = !valid_q || ready_i;
endmodule

// File: rtl/one_hot_demux.sv
// rtl/one_hot_demux.sv - steers one input stream to one of NUM_OUT lanes by a per-beat one-hot select
module one_hot_demux
    import one_hot_pkg::*;
#(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    one_hot_demux_if.slave   bus,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);
    logic [NUM_OUT-1:0] slot_free;
    logic [NUM_OUT-1:0] slot_load;
    logic               legal;
    logic               accept;
    logic               err_d, err_q;
    logic [CNT_W-1:0]   err_cnt_d, err_cnt_q;

    // Illegal selects are always sunk so the producer can never deadlock on them.
    always_comb begin
        legal          = is_onehot(MAX_N'(bus.in_sel_i));
        bus.in_ready_o = legal ? |(bus.in_sel_i & slot_free) : 1'b1;
        accept         = bus.in_valid_i && bus.in_ready_o;
        slot_load      = (accept && legal) ? bus.in_sel_i : '0;
        err_d          = accept && !legal;
        err_cnt_d      = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load_i  (slot_load[k]),
            .data_i  (bus.in_data_i),
            .ready_i (bus.out_ready_i[k]),
            .valid_o (bus.out_valid_o[k]),
            .data_o  (bus.out_data_o[k*DATA_W +: DATA_W]),
            .free_o  (slot_free[k])
        );
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
endmodule
